// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - host/pad signal bundle for the UART transmit serializer
interface uart_tx_serializer_if;
  logic [1:0] baud_rate;
  logic [1:0] parity_type;
  logic       stop_bits;
  logic [7:0] data_in;
  logic       send;
  logic       tx_out;
  logic       busy;
  logic       done;

  modport master (
    output baud_rate, parity_type, stop_bits, data_in, send,
    input  tx_out, busy, done
  );

  modport slave (
    input  baud_rate, parity_type, stop_bits, data_in, send,
    output tx_out, busy, done
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 1x-timed UART frame serializer (start, 8 data LSB-first, parity, 1/2 stop)
// Define UART_TX_PARITY_EN to build in the parity bit; otherwise parity_type is ignored.
module uart_tx_serializer #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  uart_tx_serializer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef UART_TX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t      state, state_next;
  logic [14:0] count, count_next;
  logic [14:0] last_q;
  logic [2:0]  idx, idx_next;
  logic [7:0]  data_q;
  logic        two_stop_q;
  logic        tx_q, tx_next;
  logic        busy_q, busy_next;
  logic        done_q, done_next;
  logic        accept;
  logic        bit_end;
  logic        unused_cfg;
`ifdef UART_TX_PARITY_EN
  logic        par_en_q;
  logic        par_odd_q;
`endif

  // Divisors are fixed for a 50 MHz clock; CLK_HZ is informational only.
  function automatic logic [14:0] bit_last(input logic [1:0] rate);
    case (rate)
      2'b00:   return 15'd20832;
      2'b01:   return 15'd10416;
      2'b10:   return 15'd5207;
      default: return 15'd2603;
    endcase
  endfunction

  assign accept     = (state == IDLE) && bus.send;
  assign bit_end    = (count == last_q);
  assign unused_cfg = ^bus.parity_type ^ (CLK_HZ == 0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      count  <= '0;
      idx    <= '0;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      idx    <= idx_next;
      tx_q   <= tx_next;
      busy_q <= busy_next;
      done_q <= done_next;
    end
  end

  // Frame settings are frozen at accept so host-side changes cannot disturb a frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_q     <= 15'd2603;
      data_q     <= '0;
      two_stop_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
`endif
    end else if (accept) begin
      last_q     <= bit_last(bus.baud_rate);
      data_q     <= bus.data_in;
      two_stop_q <= bus.stop_bits;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= (bus.parity_type == 2'b01) || (bus.parity_type == 2'b10);
      par_odd_q  <= (bus.parity_type == 2'b01);
`endif
    end
  end

  always_comb begin
    state_next = state;
    count_next = bit_end ? 15'd0 : count + 15'd1;
    idx_next   = idx;
    case (state)
      IDLE: begin
        count_next = '0;
        idx_next   = '0;
        if (bus.send) state_next = START;
      end
      START: begin
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        if (bit_end) begin
          idx_next = idx + 3'd1;
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = par_en_q ? PARITY : STOP;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_next = STOP;
      end
`endif
      STOP: begin
        // idx wrapped to 0 leaving DATA, so it now counts stop bits.
        if (bit_end) begin
          if (idx[0] == two_stop_q) state_next = IDLE;
          else                      idx_next   = idx + 3'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_next   = 1'b1;
    busy_next = (state_next != IDLE);
    done_next = (state == STOP) && (state_next == IDLE);
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = data_q[idx_next];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = (^data_q) ^ par_odd_q;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  assign bus.tx_out = tx_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - directed frame-vector bench for uart_tx_serializer
module tb_uart_tx_serializer;

  typedef struct {
    string       name;
    logic [7:0]  data;
    logic [1:0]  baud;
    logic [1:0]  par;
    logic        stop2;
    int          div;
    int          nbits;
    int          nchk;
    logic [11:0] line;
  } frame_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   nchecks = 0;
  int   nerr = 0;
  int   done_cnt = 0;
  int   overlap_cnt = 0;
  frame_t vec [4];

  uart_tx_serializer_if bus ();

  uart_tx_serializer #(.CLK_HZ(50_000_000)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (bus.done === 1'b1) done_cnt++;
    if (bus.done === 1'b1 && bus.busy === 1'b1) overlap_cnt++;
  end

  task automatic check_eq(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic start_frame(input int f, input bit hold);
    bus.data_in     = vec[f].data;
    bus.baud_rate   = vec[f].baud;
    bus.parity_type = vec[f].par;
    bus.stop_bits   = vec[f].stop2;
    bus.send        = 1'b1;
    @(negedge clock);
    if (!hold) bus.send = 1'b0;
  endtask

  // Entered at the first sample after the accept edge; leaves at sample N*DIV (or nchk*DIV).
  task automatic check_frame(input int f);
    int bad;
    for (int k = 0; k < vec[f].nchk; k++) begin
      bad = 0;
      for (int c = 0; c < vec[f].div; c++) begin
        if (bus.tx_out !== vec[f].line[k] || bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
        @(negedge clock);
      end
      check_eq($sformatf("%s bit %0d wrong cycles", vec[f].name, k), bad, 0);
    end
    if (vec[f].nchk == vec[f].nbits) begin
      check_eq($sformatf("%s done at end", vec[f].name), int'(bus.done), 1);
      check_eq($sformatf("%s busy at end", vec[f].name), int'(bus.busy), 0);
      check_eq($sformatf("%s tx_out at end", vec[f].name), int'(bus.tx_out), 1);
    end else begin
      check_eq($sformatf("%s tx_out at bit %0d", vec[f].name, vec[f].nchk),
               int'(bus.tx_out), int'(vec[f].line[vec[f].nchk]));
    end
  endtask

  task automatic check_idle(input string name);
    check_eq({name, " tx_out"}, int'(bus.tx_out), 1);
    check_eq({name, " busy"}, int'(bus.busy), 0);
    check_eq({name, " done"}, int'(bus.done), 0);
  endtask

  initial begin
    int bad;
    int d0;

    // Line patterns: bit k of .line is the k-th bit on the wire, start bit first.
`ifdef UART_TX_PARITY_EN
    vec[0] = '{"a5_19200_even_1stop", 8'hA5, 2'b11, 2'b10, 1'b0, 2604, 11, 11, 12'h54A};
    vec[1] = '{"0f_19200_odd_2stop",  8'h0F, 2'b11, 2'b01, 1'b1, 2604, 12, 12, 12'hE1E};
`else
    vec[0] = '{"a5_19200_even_1stop", 8'hA5, 2'b11, 2'b10, 1'b0, 2604, 10, 10, 12'h34A};
    vec[1] = '{"0f_19200_odd_2stop",  8'h0F, 2'b11, 2'b01, 1'b1, 2604, 11, 11, 12'h61E};
`endif
    vec[2] = '{"ff_9600_start",  8'hFF, 2'b10, 2'b00, 1'b0, 5208,  10, 1, 12'h3FE};
    vec[3] = '{"ff_4800_start",  8'hFF, 2'b01, 2'b11, 1'b0, 10417, 10, 1, 12'h3FE};

    bus.data_in     = 8'h00;
    bus.baud_rate   = 2'b00;
    bus.parity_type = 2'b00;
    bus.stop_bits   = 1'b0;
    bus.send        = 1'b0;

    repeat (5) @(negedge clock);
    check_idle("in reset");
    reset_n = 1'b1;
    @(negedge clock);
    check_idle("after reset");
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
      @(negedge clock);
    end
    check_eq("idle 1000 cycles wrong cycles", bad, 0);

    // Back-to-back with send held high; settings scrambled and restored mid-frame.
    d0 = done_cnt;
    start_frame(0, 1'b1);
    fork
      begin
        check_frame(0);
        @(negedge clock);
        check_frame(1);
      end
      begin
        repeat (3000) @(negedge clock);
        bus.data_in     = 8'h3C;
        bus.baud_rate   = 2'b00;
        bus.parity_type = 2'b01;
        bus.stop_bits   = 1'b1;
        repeat (12000) @(negedge clock);
        bus.data_in     = vec[1].data;
        bus.baud_rate   = vec[1].baud;
        bus.parity_type = vec[1].par;
        bus.stop_bits   = vec[1].stop2;
        repeat (15000) @(negedge clock);
        bus.send = 1'b0;
      end
    join
    repeat (5) @(negedge clock);
    check_eq("b2b done pulses", done_cnt - d0, 2);
    check_eq("b2b no third frame busy", int'(bus.busy), 0);
    check_eq("b2b no third frame tx_out", int'(bus.tx_out), 1);

    // Abort during data bit 3 (wire bit 4) of 0xF7, whose bit 3 is the only 0.
    d0 = done_cnt;
    bus.data_in   = 8'hF7;
    bus.baud_rate = 2'b11;
    bus.stop_bits = 1'b0;
    bus.send      = 1'b1;
    @(negedge clock);
    bus.send = 1'b0;
    repeat (4 * 2604 + 1000) @(negedge clock);
    check_eq("pre-abort tx_out (data bit 3)", int'(bus.tx_out), 0);
    check_eq("pre-abort busy", int'(bus.busy), 1);
    #2 reset_n = 1'b0;
    #1;
    check_idle("async abort");
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    check_eq("post-abort idle wrong cycles", bad, 0);
    check_eq("abort done pulses", done_cnt - d0, 0);

    // Start-bit timing at the other rates, each aborted by reset afterwards.
    for (int f = 2; f < 4; f++) begin
      start_frame(f, 1'b0);
      check_frame(f);
      reset_n = 1'b0;
      #1;
      check_idle({vec[f].name, " abort"});
      @(negedge clock);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);
    end

    check_eq("done and busy overlap cycles", overlap_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

UART transmit serializer that converts a parallel byte into an asynchronous serial frame on the `tx_out` line. The frame is start bit, 8 data bits LSB-first, optional parity bit, and 1 or 2 stop bits. It is the transmit counterpart of the receiver path and uses the same 50 MHz system clock and the same 2-bit baud-rate encoding. Bit timing is 1x, so bit periods come from an internal divider with no oversampling. The block sits between the host-side byte interface and the pad.

## Interface
Parameters:
- `CLK_HZ`, default 50_000_000: system clock frequency. Documentation only; the divisor constants below are fixed for 50 MHz.

Ports:
- `clock`  in  1: system clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `baud_rate`  in  2: 00 = 2400, 01 = 4800, 10 = 9600, 11 = 19200 baud.
- `parity_type`  in  2: 00 = none, 01 = odd, 10 = even, 11 = none.
- `stop_bits`  in  1: 0 = one stop bit, 1 = two stop bits.
- `data_in`  in  8: byte to transmit.
- `send`  in  1: request. The frame is accepted on the rising edge where `send && !busy`.
- `tx_out`  out  1: serial line. Idle high.
- `busy`  out  1: high while a frame is in flight.
- `done`  out  1: one-cycle pulse when a frame completes.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Accept: in IDLE with `send=1`, the block latches `data_in`, `baud_rate`, `parity_type` and `stop_bits` into shadow registers.
  - Input changes during a frame are ignored.
  - `send` while busy is ignored; it is not queued.
- Bit period DIV (clock cycles):
  - 2400 baud: 20833
  - 4800 baud: 10417
  - 9600 baud: 5208
  - 19200 baud: 2604
- Bit timer: 15-bit counter that runs 0..DIV-1 and clears to 0 at every bit boundary and on accept. Every bit is held exactly DIV cycles.
- START: drives 0 for one bit period, then goes to DATA.
- DATA: drives `data[idx]` with `idx` running 0..7 (3-bit index). After bit 7 the FSM goes to PARITY if parity is enabled, otherwise to STOP.
- PARITY:
  - even: drives `^data`.
  - odd: drives `~^data`.
- STOP: drives 1 for 1 or 2 bit periods, then goes to IDLE.
- Frame length N:
  - 1 start + 8 data + 1 stop = 10 bits.
  - +1 if parity is enabled.
  - +1 if two stop bits are selected.
  - Range 10..12 bits.

## Timing
- Reset values: `tx_out=1`, `busy=0`, `done=0`, FSM=IDLE, counter=0, index=0.
- Reset asserted mid-frame aborts the frame immediately; `tx_out` goes high asynchronously. No `done` pulse is issued for the aborted frame.
- Accept edge E0:
  - `tx_out` falls to 0 and `busy` rises at E0 (registered outputs).
  - Latency from the sampled `send` to the start bit is 0 cycles after the edge.
- Bit k (k = 0..N-1) is driven on `tx_out` from edge E0+k·DIV to E0+(k+1)·DIV.
- At edge E0+N·DIV:
  - `busy` falls and `done` rises for exactly one cycle.
  - `tx_out` stays 1 and the FSM returns to IDLE.
- Back-to-back frames: the earliest next accept is edge E0+N·DIV+1, so there is exactly one extra idle-high cycle between frames.
- `done` and `busy` are never high in the same cycle.
- Counter wrap: the compare is `count == DIV-1`. The counter never exceeds 20832.

## Configuration
- Macro `UART_TX_PARITY_EN`.
- Defined: parity is supported as described; the PARITY state exists.
- Undefined:
  - The PARITY state and parity logic are removed.
  - `parity_type` is still a port but is ignored.
  - N is 10 or 11 bits.

## Test plan
- Reset idle: hold `reset_n=0`, then release. Expect `tx_out=1`, `busy=0` and `done=0`, stable for 1000 cycles with `send=0`.
- 0xA5 at 19200 baud, even parity, 1 stop bit:
  - Line sequence 0,1,0,1,0,0,1,0,1,0,1, each held 2604 cycles.
  - `done` pulses at E0+28644.
- 0x00 at 9600 baud, odd parity, 2 stop bits:
  - Line sequence 0, eight 0s, parity 1, then 1,1, each held 5208 cycles.
  - `busy` is high for 62496 cycles.
- Back-to-back 0x55 then 0x0F at 2400 baud, no parity:
  - `send` held high continuously.
  - The second start bit begins exactly at E0+208331.
  - Exactly one `done` pulse per frame.
- Mid-frame changes at 4800 baud: toggle `baud_rate`, `data_in` and `send` during the frame. Expect the frame unaffected, with all bits 10417 cycles.
- Reset during DATA bit 3: expect `tx_out=1` at once, `busy=0`, no `done` pulse, and the next `send` starts a clean frame.
